// File: rtl/seq_adder.sv
// Digit-serial adder/subtractor: latches operands, adds DIGIT bits per cycle LSB-first.
// Latency: WIDTH/DIGIT busy cycles after the accept edge, then a one-cycle done pulse.
// Backpressure: start is accepted only when busy=0; start during RUN is ignored.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start          request; sampled in IDLE or DONE
//   sub            0 = a+b+cin, 1 = a-b (cin ignored); latched at accept
//   a, b, cin      operands and add-mode carry-in; latched at accept
//   busy           high while digits are being processed
//   done           one-cycle result-valid pulse
//   sum            result, held until the next accept or reset
//   cout           carry out of MSB (sub mode: 1 = no borrow)
//   overflow       two's-complement overflow of the operation

module seq_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH_W  = $clog2(WIDTH) + 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("seq_adder: need WIDTH >= 2, 1 <= DIGIT <= WIDTH, WIDTH %% DIGIT == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    // Digit slice datapath
    logic [SH_W-1:0]    shamt;
    logic [DIGIT-1:0]   a_dig;
    logic [DIGIT-1:0]   b_dig;
    logic [DIGIT-1:0]   s_dig;
    logic               c_dig;
    logic               msb_cin;
    logic [WIDTH-1:0]   dig_mask;
    logic               last_dig;

    always_comb begin
        shamt    = SH_W'(cnt_q) * SH_W'(DIGIT);
        a_dig    = DIGIT'(a_q >> shamt);
        b_dig    = DIGIT'(b_q >> shamt);
        {c_dig, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT+1)'(carry_q);
        // Carry into the slice MSB recovered from the sum bit: s = a ^ b ^ cin.
        msb_cin  = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1];
        dig_mask = WIDTH'({DIGIT{1'b1}}) << shamt;
        last_dig = (cnt_q == CNT_W'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                done_d = 1'b0;
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b once here, force carry-in.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~dig_mask) | ((WIDTH'(s_dig) << shamt) & dig_mask);
                carry_d = c_dig;
                if (last_dig) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = c_dig;
                    ovf_d   = c_dig ^ msb_cin;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: eight instances with different WIDTH/DIGIT share operand buses,
// each with its own start. Directed table, multi-cycle corner sequences, random sweep.
// Outputs are sampled on the falling edge; inputs change on the falling edge.

module tb_seq_adder;

    localparam int NI = 8;
    localparam int WS [0:NI-1] = '{8, 8, 8, 16, 16, 16, 16, 16};
    localparam int DS [0:NI-1] = '{1, 4, 8, 1, 2, 4, 8, 16};

    logic          clk;
    logic          reset;
    logic [NI-1:0] start_v;
    logic          sub_i;
    logic          cin_i;
    logic [15:0]   a_bus;
    logic [15:0]   b_bus;
    logic          busy_w [NI];
    logic          done_w [NI];
    logic          cout_w [NI];
    logic          ovf_w  [NI];
    logic [15:0]   sum_w  [NI];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [WS[g]-1:0] s;
        seq_adder #(.WIDTH(WS[g]), .DIGIT(DS[g])) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start_v[g]),
            .sub      (sub_i),
            .a        (a_bus[WS[g]-1:0]),
            .b        (b_bus[WS[g]-1:0]),
            .cin      (cin_i),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .sum      (s),
            .cout     (cout_w[g]),
            .overflow (ovf_w[g])
        );
        assign sum_w[g] = 16'(s);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at the first falling edge after the accept edge; counts busy cycles until done.
    task automatic wait_done(input int k, output int lat);
        lat = 0;
        for (int g = 0; g < 64; g++) begin
            if (done_w[k]) break;
            if (busy_w[k]) lat++;
            @(negedge clk);
        end
    endtask

    // Reference: {overflow, cout, sum} for a w-bit add or subtract.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic cin);
        logic [16:0] mask, av, bv, full;
        logic        c, ov;
        mask = (17'd1 << w) - 17'd1;
        av   = {1'b0, a} & mask;
        bv   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        c    = sub ? 1'b1 : cin;
        full = av + bv + {16'd0, c};
        ov   = (av[w-1] == bv[w-1]) && (full[w-1] != av[w-1]);
        return {ov, full[w], full[15:0] & mask[15:0]};
    endfunction

    // One complete operation on instance k with all result and timing checks.
    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin, input logic [15:0] es,
                          input logic ec, input logic eo, input string nm);
        int lat;
        @(negedge clk);
        a_bus = a; b_bus = b; sub_i = sub; cin_i = cin;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        // Scramble inputs: the result must come from the latched operands.
        a_bus = 16'($urandom); b_bus = 16'($urandom); sub_i = ~sub; cin_i = ~cin;
        chk({nm, ".busy"}, 32'(busy_w[k]), 32'd1);
        wait_done(k, lat);
        chk({nm, ".done"}, 32'(done_w[k]), 32'd1);
        chk({nm, ".lat"},  32'(lat), 32'(WS[k] / DS[k]));
        chk({nm, ".sum"},  32'(sum_w[k]), 32'(es));
        chk({nm, ".cout"}, 32'(cout_w[k]), 32'(ec));
        chk({nm, ".ovf"},  32'(ovf_w[k]), 32'(eo));
        @(negedge clk);
        chk({nm, ".pulse"}, 32'(done_w[k]), 32'd0);
    endtask

    typedef struct {
        int          k;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int          lat;
        logic [17:0] m;
        logic [15:0] ra, rb;
        logic        rc;

        // k  a        b        sub  cin   sum      cout overflow
        tbl[0] = '{0, 16'h005A, 16'h003C, 1'b0, 1'b0, 16'h0096, 1'b0, 1'b1};
        tbl[1] = '{0, 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
        tbl[2] = '{0, 16'h0010, 16'h0020, 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0};
        tbl[3] = '{1, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1};
        tbl[4] = '{2, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1};
        tbl[5] = '{3, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[6] = '{7, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[7] = '{5, 16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

        reset = 1'b1; start_v = '0; sub_i = 1'b0; cin_i = 1'b0; a_bus = '0; b_bus = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst%0d.busy", k), 32'(busy_w[k]), 32'd0);
            chk($sformatf("rst%0d.done", k), 32'(done_w[k]), 32'd0);
            chk($sformatf("rst%0d.sum", k),  32'(sum_w[k]),  32'd0);
            chk($sformatf("rst%0d.cout", k), 32'(cout_w[k]), 32'd0);
            chk($sformatf("rst%0d.ovf", k),  32'(ovf_w[k]),  32'd0);
        end

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin,
                   tbl[i].es, tbl[i].ec, tbl[i].eo, $sformatf("tbl%0d", i));

        // Start held high through RUN with changing operands: only the first is used.
        @(negedge clk);
        a_bus = 16'h0011; b_bus = 16'h0022; sub_i = 1'b0; cin_i = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        a_bus = 16'h00AA; b_bus = 16'h0055; sub_i = 1'b1;
        repeat (4) @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, lat);
        chk("hold.done", 32'(done_w[0]), 32'd1);
        chk("hold.sum",  32'(sum_w[0]),  32'h33);
        @(negedge clk);
        chk("hold.pulse", 32'(done_w[0]), 32'd0);

        // Back-to-back on WIDTH=8, DIGIT=4: start in the DONE cycle is accepted.
        @(negedge clk);
        a_bus = 16'h0012; b_bus = 16'h0034; sub_i = 1'b0; cin_i = 1'b0; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        wait_done(1, lat);
        chk("b2b.done1", 32'(done_w[1]), 32'd1);
        chk("b2b.sum1",  32'(sum_w[1]),  32'h46);
        a_bus = 16'h000F; b_bus = 16'h0001; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        chk("b2b.drop", 32'(done_w[1]), 32'd0);
        chk("b2b.busy", 32'(busy_w[1]), 32'd1);
        wait_done(1, lat);
        chk("b2b.done2", 32'(done_w[1]), 32'd1);
        chk("b2b.lat2",  32'(lat), 32'd2);
        chk("b2b.sum2",  32'(sum_w[1]), 32'h10);
        @(negedge clk);
        chk("b2b.pulse", 32'(done_w[1]), 32'd0);

        // Reset mid-RUN at count=3, after a result with cout=1 is held.
        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, "pre_rst");
        @(negedge clk);
        a_bus = 16'h005A; b_bus = 16'h003C; sub_i = 1'b0; cin_i = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst.busy", 32'(busy_w[0]), 32'd0);
        chk("mid_rst.done", 32'(done_w[0]), 32'd0);
        chk("mid_rst.sum",  32'(sum_w[0]),  32'd0);
        chk("mid_rst.cout", 32'(cout_w[0]), 32'd0);
        chk("mid_rst.ovf",  32'(ovf_w[0]),  32'd0);
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "post_rst");

        // Random sweep on the WIDTH=16 instances, both modes.
        for (int k = 3; k < NI; k++) begin
            for (int md = 0; md < 2; md++) begin
                for (int v = 0; v < 150; v++) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rc = 1'($urandom);
                    m  = model(16, ra, rb, md[0], rc);
                    run_op(k, ra, rb, md[0], rc, m[15:0], m[16], m[17],
                           $sformatf("rnd.k%0d.m%0d.v%0d", k, md, v));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
